// File: rtl/seq1_bist_pkg.sv
// Shared types, constants and update functions for the seq1 self-test driver/checker.
// Both the top level and the misr8 compactor use the same step functions.
package seq1_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned LFSR_W = 4;
  localparam int unsigned RESP_W = 3;
  localparam int unsigned MISR_W = 8;
  localparam int unsigned CNT_W  = 8;

  // Feedback taps for x^4+x^3+1: bits 3 and 2 feed the new LSB
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 4'b1100;
  localparam logic [MISR_W-1:0] MISR_POLY    = 8'h1D;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 4'b0001;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] m,
                                                  input logic [RESP_W-1:0] d);
    return {m[MISR_W-2:0], 1'b0}
         ^ (m[MISR_W-1] ? MISR_POLY : MISR_W'(0))
         ^ {(MISR_W-RESP_W)'(0), d};
  endfunction

endpackage

// File: rtl/seq1_bist_misr8.sv
// 8-bit multiple-input signature register compacting the 3-bit seq1 response.
// Clear wins over enable so a restart never folds a stale response in.
module misr8
  import seq1_bist_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              EN,
  input  logic [RESP_W-1:0] D,
  output logic [MISR_W-1:0] Q
);

  logic [MISR_W-1:0] r_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= '0;
    end else if (CLR) begin
      r_q <= '0;
    end else if (EN) begin
      r_q <= misr_next(r_q, D);
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/seq1_bist.sv
// Self-test driver/checker for seq1: LFSR stimulus out on I_OUT, MISR compaction of
// S_IN aligned by a LAT-deep valid pipe, and a final signature compare against EXP_SIG.
module seq1_bist
  import seq1_bist_pkg::*;
#(
  parameter int unsigned       N_PATTERNS = 15,
  parameter int unsigned       LAT        = 2,
  parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [RESP_W-1:0] S_IN,
  input  logic [MISR_W-1:0] EXP_SIG,
  output logic [LFSR_W-1:0] I_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic [MISR_W-1:0] SIG,
  output logic              PASS
);

  // An all-zero seed would lock the LFSR, so it is replaced by the default
  localparam logic [LFSR_W-1:0] SEED_L   = (SEED == '0) ? DEFAULT_SEED : SEED;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_PATTERNS);
  localparam logic [LAT-1:0]    VP_LAST  = LAT'(1 << (LAT - 1));

  state_e            r_state, w_state_nxt;
  logic [LFSR_W-1:0] r_lfsr, w_lfsr_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [LAT-1:0]    r_vpipe, w_vpipe_nxt;
  logic [LFSR_W-1:0] r_iout, w_iout_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [MISR_W-1:0] r_sig, w_sig_nxt;
  logic              r_pass, w_pass_nxt;
  logic              w_misr_clr;
  logic              w_absorb;
  logic [MISR_W-1:0] w_misr_q;
  logic [MISR_W-1:0] w_misr_fin;

  // Bit 0 marks that the previous cycle presented a pattern; the top bit gates absorption
  assign w_vpipe_nxt = (r_vpipe << 1) | LAT'(r_state == ST_RUN);
  assign w_absorb    = r_vpipe[LAT-1];
  assign w_misr_fin  = misr_next(w_misr_q, S_IN);

  misr8 u_misr (
    .CLK (CLK),
    .RST (RST),
    .CLR (w_misr_clr),
    .EN  (w_absorb),
    .D   (S_IN),
    .Q   (w_misr_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_lfsr  <= SEED_L;
      r_cnt   <= '0;
      r_vpipe <= '0;
      r_iout  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sig   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vpipe <= w_vpipe_nxt;
      r_iout  <= w_iout_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_sig   <= w_sig_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_cnt_nxt   = r_cnt;
    w_iout_nxt  = r_iout;
    w_done_nxt  = r_done;
    w_sig_nxt   = r_sig;
    w_pass_nxt  = r_pass;
    w_misr_clr  = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          w_state_nxt = ST_RUN;
          w_iout_nxt  = SEED_L;
          w_lfsr_nxt  = lfsr_next(SEED_L);
          w_cnt_nxt   = CNT_W'(1);
          w_misr_clr  = 1'b1;
          w_done_nxt  = 1'b0;
          w_sig_nxt   = '0;
          w_pass_nxt  = 1'b0;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_FLUSH;
          w_iout_nxt  = '0;
        end else begin
          w_iout_nxt = r_lfsr;
          w_lfsr_nxt = lfsr_next(r_lfsr);
          w_cnt_nxt  = r_cnt + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        // Only the final response remains in flight: it is absorbed on this edge
        if (r_vpipe == VP_LAST) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_sig_nxt   = w_misr_fin;
          w_pass_nxt  = (w_misr_fin == EXP_SIG);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_FLUSH);

  assign I_OUT = r_iout;
  assign BUSY  = r_busy;
  assign DONE  = r_done;
  assign SIG   = r_sig;
  assign PASS  = r_pass;

endmodule

// File: tb/tb_seq1_bist.sv
// Directed bench for seq1_bist: default build plus N_PATTERNS=2, N_PATTERNS=9 and SEED=0
// builds sharing clock, reset and start, with hand-computed stimulus and signatures.
module tb_seq1_bist;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;

  logic [2:0] def_s = '0, n2_s = '0, n9_s = '0, s0_s = '0;
  logic [7:0] def_exp = '0, n2_exp = '0, n9_exp = '0, s0_exp = '0;

  logic [3:0] def_iout, n2_iout, n9_iout, s0_iout;
  logic       def_busy, n2_busy, n9_busy, s0_busy;
  logic       def_done, n2_done, n9_done, s0_done;
  logic [7:0] def_sig, n2_sig, n9_sig, s0_sig;
  logic       def_pass, n2_pass, n9_pass, s0_pass;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                           4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  always #5 CLK = ~CLK;

  seq1_bist u_def (
    .CLK(CLK), .RST(RST), .START(START), .S_IN(def_s), .EXP_SIG(def_exp),
    .I_OUT(def_iout), .BUSY(def_busy), .DONE(def_done), .SIG(def_sig), .PASS(def_pass)
  );

  seq1_bist #(.N_PATTERNS(2)) u_n2 (
    .CLK(CLK), .RST(RST), .START(START), .S_IN(n2_s), .EXP_SIG(n2_exp),
    .I_OUT(n2_iout), .BUSY(n2_busy), .DONE(n2_done), .SIG(n2_sig), .PASS(n2_pass)
  );

  seq1_bist #(.N_PATTERNS(9)) u_n9 (
    .CLK(CLK), .RST(RST), .START(START), .S_IN(n9_s), .EXP_SIG(n9_exp),
    .I_OUT(n9_iout), .BUSY(n9_busy), .DONE(n9_done), .SIG(n9_sig), .PASS(n9_pass)
  );

  seq1_bist #(.SEED(4'b0000)) u_s0 (
    .CLK(CLK), .RST(RST), .START(START), .S_IN(s0_s), .EXP_SIG(s0_exp),
    .I_OUT(s0_iout), .BUSY(s0_busy), .DONE(s0_done), .SIG(s0_sig), .PASS(s0_pass)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full default-build run from the START edge E0 through E17
  task automatic run_def(input bit extra, input bit hold, input logic [7:0] exp_sig);
    START = 1'b1;
    tick();
    if (!hold) START = 1'b0;
    chk("e0_iout", 32'(def_iout), 32'(seq[0]));
    chk("e0_busy", 32'(def_busy), 32'd1);
    if (extra) chk("seed0_first_iout", 32'(s0_iout), 32'h1);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k <= 14) chk($sformatf("iout_e%0d", k), 32'(def_iout), 32'(seq[k]));
      else         chk($sformatf("iout_flush_e%0d", k), 32'(def_iout), 32'h0);
      if (k < 17) begin
        chk($sformatf("busy_e%0d", k), 32'(def_busy), 32'd1);
        chk($sformatf("done_e%0d", k), 32'(def_done), 32'd0);
      end else begin
        chk("busy_end", 32'(def_busy), 32'd0);
        chk("done_end", 32'(def_done), 32'd1);
        chk("sig_end", 32'(def_sig), 32'(exp_sig));
        chk("pass_end", 32'(def_pass), 32'd1);
      end
      if (extra) begin
        if (k == 1) chk("seed0_second_iout", 32'(s0_iout), 32'h2);
        if (k == 3) chk("n2_done_early", 32'(n2_done), 32'd0);
        if (k == 4) begin
          chk("n2_done", 32'(n2_done), 32'd1);
          chk("n2_sig", 32'(n2_sig), 32'h03);
          chk("n2_pass", 32'(n2_pass), 32'd1);
        end
        if (k == 11) begin
          chk("n9_done", 32'(n9_done), 32'd1);
          chk("n9_sig", 32'(n9_sig), 32'h1D);
          chk("n9_pass", 32'(n9_pass), 32'd1);
        end
        n9_s = (k == 2) ? 3'b001 : 3'b000;
      end
    end
  endtask

  initial begin
    // Reset held two cycles with START high must not launch a run
    RST   = 1'b1;
    START = 1'b1;
    tick();
    tick();
    chk("rst_def", 32'({def_iout, def_busy, def_done, def_sig, def_pass}), 32'h0);
    chk("rst_n2",  32'({n2_iout, n2_busy, n2_done, n2_sig, n2_pass}), 32'h0);
    chk("rst_n9",  32'({n9_iout, n9_busy, n9_done, n9_sig, n9_pass}), 32'h0);
    chk("rst_s0",  32'({s0_iout, s0_busy, s0_done, s0_sig, s0_pass}), 32'h0);
    RST   = 1'b0;
    START = 1'b0;
    tick();
    chk("idle_busy", 32'(def_busy), 32'd0);
    chk("idle_iout", 32'(def_iout), 32'h0);

    // Default run with zero response; N=2 and N=9 builds checked alongside
    def_s  = 3'b000; def_exp = 8'h00;
    n2_s   = 3'b001; n2_exp  = 8'h03;
    n9_s   = 3'b000; n9_exp  = 8'h1D;
    run_def(1'b1, 1'b0, 8'h00);

    // N=2 with a wrong expectation, then reset during the 5th RUN cycle
    n2_exp  = 8'h04;
    def_s   = 3'b001;
    def_exp = 8'h1D;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    chk("n2_fail_done", 32'(n2_done), 32'd1);
    chk("n2_fail_sig", 32'(n2_sig), 32'h03);
    chk("n2_fail_pass", 32'(n2_pass), 32'd0);
    chk("midrun_iout", 32'(def_iout), 32'(seq[4]));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_iout", 32'(def_iout), 32'h0);
    chk("midrst_busy", 32'(def_busy), 32'd0);
    chk("midrst_done", 32'(def_done), 32'd0);
    tick();
    chk("midrst_idle", 32'(def_busy), 32'd0);

    // Replay after reset: constant response 1 compacts to 8'h1D over 15 patterns
    run_def(1'b0, 1'b0, 8'h1D);

    // START held through the run: same signature, then immediate restart from DONE
    run_def(1'b0, 1'b1, 8'h1D);
    tick();
    START = 1'b0;
    chk("restart_done", 32'(def_done), 32'd0);
    chk("restart_busy", 32'(def_busy), 32'd1);
    chk("restart_iout", 32'(def_iout), 32'h1);
    chk("restart_sig", 32'(def_sig), 32'h00);
    for (int k = 1; k <= 17; k++) tick();
    chk("restart_end_done", 32'(def_done), 32'd1);
    chk("restart_end_sig", 32'(def_sig), 32'h1D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
